// File: rtl/lieat_clint_bridge_pkg.sv
// Shared constants for the CLINT slave bridge: window offsets, timer word
// selects and the response FSM state type.
package lieat_clint_bridge_pkg;

  localparam logic [15:0] CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFS    = 16'hBFFC;

  localparam logic [1:0] BSEL_MTIMECMP_LO = 2'd0;
  localparam logic [1:0] BSEL_MTIMECMP_HI = 2'd1;
  localparam logic [1:0] BSEL_MTIME_LO    = 2'd2;
  localparam logic [1:0] BSEL_MTIME_HI    = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/lieat_clint_bridge_dec.sv
// Combinational CLINT window decode: register hit, timer word select and
// address error (misaligned, outside the 64 KiB window, or unmapped offset).
module lieat_clint_bridge_dec
  import lieat_clint_bridge_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic [31:0] addr,
  output logic        hit_msip,
  output logic        hit_tcmp,
  output logic [1:0]  bsel,
  output logic        err_addr
);

  logic        base_hit;
  logic [15:0] ofs;

  assign base_hit = (addr[31:16] == CLINT_BASE[31:16]);
  assign ofs      = addr[15:0];

  // Hits require word alignment, so a misaligned address falls through to err_addr.
  always_comb begin
    hit_msip = 1'b0;
    hit_tcmp = 1'b0;
    bsel     = BSEL_MTIMECMP_LO;
    if (base_hit && (addr[1:0] == 2'b00)) begin
      unique case (ofs)
        CLINT_MSIP_OFS:        hit_msip = 1'b1;
        CLINT_MTIMECMP_LO_OFS: begin hit_tcmp = 1'b1; bsel = BSEL_MTIMECMP_LO; end
        CLINT_MTIMECMP_HI_OFS: begin hit_tcmp = 1'b1; bsel = BSEL_MTIMECMP_HI; end
        CLINT_MTIME_LO_OFS:    begin hit_tcmp = 1'b1; bsel = BSEL_MTIME_LO;    end
        CLINT_MTIME_HI_OFS:    begin hit_tcmp = 1'b1; bsel = BSEL_MTIME_HI;    end
        default: ;
      endcase
    end
  end

  assign err_addr = ~(hit_msip | hit_tcmp);

endmodule

// File: rtl/lieat_general_dfflr.sv
// Load-enabled register with synchronous active-high reset to zero.
module lieat_general_dfflr #(
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clock) begin
    if (reset) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/lieat_clint_bridge.sv
// LSU-to-CLINT slave adapter: valid/ready request channel, byte-merged RMW
// stores into msip/mtimecmp, one registered response per request.
module lieat_clint_bridge
  import lieat_clint_bridge_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_addr,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [3:0]      req_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            clint_timeset_wen,
  output logic [1:0]      clint_timeset_bsel,
  output logic [XLEN-1:0] clint_timeset_wdata,
  input  logic [XLEN-1:0] clint_timeset_rdata,
  output logic            clint_msipset_wen,
  output logic [XLEN-1:0] clint_msipset_wdata,
  input  logic [XLEN-1:0] clint_msipset_rdata
);

  state_e          state_q;
  logic            hit_msip;
  logic            hit_tcmp;
  logic            err_addr;
  logic            err;
  logic            accept;
  logic            wr_ok;
  logic [XLEN-1:0] cur_rdata;
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] rdata_nxt;
  logic [XLEN:0]   rsp_q;

  lieat_clint_bridge_dec #(
    .CLINT_BASE (CLINT_BASE)
  ) u_dec (
    .addr     (req_addr),
    .hit_msip (hit_msip),
    .hit_tcmp (hit_tcmp),
    .bsel     (clint_timeset_bsel),
    .err_addr (err_addr)
  );

  assign req_ready = (state_q == ST_IDLE) | rsp_ready;
  assign accept    = req_valid & req_ready & ~reset;

  // Stores to mtime lo/hi (bsel[1] set) are read-only errors.
  assign err       = err_addr | (req_wen & hit_tcmp & clint_timeset_bsel[1]);
  assign wr_ok     = accept & req_wen & ~err;

  assign cur_rdata = hit_msip ? {{(XLEN-1){1'b0}}, clint_msipset_rdata[0]}
                              : clint_timeset_rdata;

  always_comb begin
    merged = cur_rdata;
    for (int unsigned i = 0; i < XLEN/8; i++) begin
      if (req_wstrb[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  assign clint_timeset_wen   = wr_ok & hit_tcmp;
  assign clint_timeset_wdata = merged;
  assign clint_msipset_wen   = wr_ok & hit_msip;
  assign clint_msipset_wdata = {{(XLEN-1){1'b0}}, merged[0]};

  assign rdata_nxt = (req_wen | err) ? '0 : cur_rdata;

  lieat_general_dfflr #(
    .DW (XLEN + 1)
  ) u_rsp_dff (
    .clock (clock),
    .reset (reset),
    .lden  (accept),
    .dnxt  ({err, rdata_nxt}),
    .qout  (rsp_q)
  );

  assign rsp_err   = rsp_q[XLEN];
  assign rsp_rdata = rsp_q[XLEN-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      state_q <= ST_RESP;
    end else if (rsp_ready) begin
      state_q <= ST_IDLE;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);

endmodule

// File: doc/lieat_clint_bridge.md
Name: lieat_clint_bridge

Overview:
- Memory-mapped slave adapter directly upstream of lieat_clint.
- Accepts LSU load/store requests over a valid/ready channel and decodes the CLINT address window.
- Drives the CLINT msip and timer set/read ports, merging byte-strobed writes by read-modify-write.
- Returns one registered response per request, with an error flag for illegal accesses.

Parameters:
- CLINT_BASE, 32'h0200_0000, base address of the CLINT window.
- XLEN, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when high together with req_valid
- req_addr  input  32  byte address
- req_wen  input  1  1 = store, 0 = load
- req_wdata  input  32  store data
- req_wstrb  input  4  byte enables for the store; ignored on loads
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed
- rsp_rdata  output  32  load data; 0 on stores and on errors
- rsp_err  output  1  access error
- clint_timeset_wen  output  1  mtimecmp write strobe
- clint_timeset_bsel  output  2  0 = mtimecmp lo, 1 = mtimecmp hi, 2 = mtime lo, 3 = mtime hi
- clint_timeset_wdata  output  32  merged write data
- clint_timeset_rdata  input  32  combinational read of the selected timer word
- clint_msipset_wen  output  1  msip write strobe
- clint_msipset_wdata  output  32  merged msip data
- clint_msipset_rdata  input  32  current msip value

Behaviour:
- Address map (offsets from CLINT_BASE):
  - 0x0000 = msip
  - 0x4000 = mtimecmp lo
  - 0x4004 = mtimecmp hi
  - 0xBFF8 = mtime lo
  - 0xBFFC = mtime hi
  - Any other address is unmapped.
- Error conditions:
  - req_addr[1:0] != 0 (misaligned).
  - Unmapped address.
  - Store to mtime lo or mtime hi (read-only).
  - Store with req_wstrb == 0 is not an error; it completes as a no-op write.
- States:
  - IDLE: rsp_valid = 0.
  - RESP: rsp_valid = 1.
- req_ready = (state == IDLE) | rsp_ready. A new request is accepted in the same cycle the old response is consumed, giving back-to-back throughput of 1 per cycle.
- Accept cycle (req_valid & req_ready):
  - clint_timeset_bsel is decoded combinationally from req_addr. It defaults to 0 when no mtime/mtimecmp address is hit.
  - Merged data, per byte i: req_wstrb[i] ? req_wdata byte i : current rdata byte i.
  - msip store: clint_msipset_wdata = {31'b0, merged[0]}. Bits 31:1 always read 0.
  - Write strobes are asserted only in the accept cycle, only for legal stores, and only while req_valid & req_ready. They are never asserted on an error.
  - Load data is taken from the CLINT rdata in the accept cycle and registered. mtime returns the value present in the accept cycle.
  - rsp_rdata, rsp_err and state = RESP are registered at the next clock edge. Latency is 1 cycle.
- RESP state:
  - rsp_ready = 1 with no new request → IDLE.
  - rsp_ready = 1 with a new request → stay in RESP with the new response.
  - rsp_ready = 0 → hold rsp_valid, rsp_rdata and rsp_err stable; req_ready = 0.
- Reset values: state = IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. All CLINT write strobes are 0 during reset.
- Reset mid-operation: a pending response is dropped. A write already strobed in an earlier cycle is not undone.
- No 64-bit atomicity: the mtime lo/hi rollover between two loads is visible to software.
- Unused address bits above the window are compared in full against CLINT_BASE; the window size is 64 KiB.

Decomposition:
- Shared package holds:
  - Offset constants CLINT_MSIP_OFS, CLINT_MTIMECMP_LO_OFS, CLINT_MTIMECMP_HI_OFS, CLINT_MTIME_LO_OFS, CLINT_MTIME_HI_OFS.
  - Bsel encodings.
  - The 1-bit state encoding.
- Sub-module lieat_clint_bridge_dec: purely combinational address decode producing hit_msip, hit_tcmp, bsel, err_addr. Merge, handshake and registers stay in the top.
- Response registers use lieat_general_dfflr.

Test Plan:
- Store 0x0200_4000, wdata 0x0000_1234, wstrb 0xF; then load the same address → clint_timeset_wen pulses for exactly 1 cycle with bsel = 0; load returns 0x0000_1234 with rsp_err = 0.
- Store 0x0200_4004, wdata 0xAABB_CCDD, wstrb 0x2, with mtimecmp hi = 0xFFFF_FFFF → wdata = 0xFFFF_CCFF; a subsequent load returns 0xFFFF_CCFF.
- Store 0x0200_0000, wdata 0xFFFF_FFFF → msip wdata = 0x1; load returns 0x0000_0001. Store wdata 0xFFFF_FFFE → msip cleared.
- Load 0x0200_BFF8 twice, back-to-back with rsp_ready tied to 1 → one response per cycle; the second value is greater than the first by 1.
- Store 0x0200_BFF8, and separately load 0x0200_4002 and 0x0200_8000 → rsp_err = 1, rsp_rdata = 0, no write strobe asserted.
- Hold rsp_ready = 0 for 5 cycles → rsp_valid/rsp_rdata stay stable, req_ready = 0, no extra strobes. Assert reset during RESP → rsp_valid = 0 on the next cycle.
